// File: rtl/aes_bus_sequencer.sv
// aes_bus_sequencer: bus master that configures the AES register core and streams blocks through it.
module aes_bus_sequencer #(
    parameter logic [23:0] BASE_ADDR  = 24'h000000,
    parameter int          POLL_LIMIT = 1024
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         cfg_start,
    input  logic [127:0] cfg_key,
    input  logic [127:0] cfg_iv,
    input  logic         cfg_encdec,
    input  logic [1:0]   cfg_mode,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    output logic         m_valid,
    output logic         m_wen,
    output logic [23:0]  m_addr,
    output logic [31:0]  m_wdata,
    input  logic [31:0]  m_rdata,
    input  logic         m_ready,
    output logic         busy,
    output logic         error
);
    localparam int PW = $clog2(POLL_LIMIT + 1) > 10 ? $clog2(POLL_LIMIT + 1) : 10;
    typedef enum logic [3:0] {IDLE, CFG, WAIT_IN, PT_WR, GO, GAP, POLL, CT_RD, OUT} state_t;
    state_t         state, state_nx;
    logic [3:0]     cnt;
    logic [PW-1:0]  poll_cnt;
    logic [127:0]   key_r, iv_r, blk_r;
    logic           encdec_r;
    logic [1:0]     mode_r;
    logic [7:0]     off;
    logic [1:0]     cfg_i;
    logic           xfer, cfg_acc, poll_tmo;

    function automatic logic [31:0] word(input logic [127:0] v, input logic [1:0] i);
        return i == 2'd0 ? v[127:96] : i == 2'd1 ? v[95:64] : i == 2'd2 ? v[63:32] : v[31:0];
    endfunction

    assign xfer      = m_valid && m_ready;
    assign cfg_acc   = cfg_start && (state == IDLE || state == WAIT_IN);
    assign poll_tmo  = state == POLL && xfer && !m_rdata[0] && poll_cnt == PW'(POLL_LIMIT - 1);
    // KEY occupies counts 2..5 and IV 6..9; both map to word 0..3 by subtracting 2 mod 4
    assign cfg_i     = cnt[1:0] - 2'd2;
    assign m_addr    = m_valid ? BASE_ADDR + {16'h0, off} : '0;
    assign busy      = state != IDLE && state != WAIT_IN;
    assign out_valid = state == OUT;

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        m_valid  = 1'b0;
        m_wen    = 1'b0;
        off      = '0;
        m_wdata  = '0;
        case (state)
            IDLE: state_nx = cfg_start ? CFG : IDLE;
            CFG: begin
                m_valid = 1'b1;
                m_wen   = 1'b1;
                off     = cnt < 4'd2 ? 8'h00 : cnt < 4'd6 ? 8'h04 + {4'h0, cfg_i, 2'b00}
                                                          : 8'h24 + {4'h0, cfg_i, 2'b00};
                m_wdata = cnt == 4'd0 ? 32'h1 : cnt == 4'd1 ? {27'h0, mode_r, encdec_r, 2'b00}
                        : cnt < 4'd6 ? word(key_r, cfg_i) : word(iv_r, cfg_i);
                if (xfer && cnt == 4'd9) state_nx = WAIT_IN;
            end
            WAIT_IN: begin
                in_ready = !cfg_start;
                state_nx = cfg_start ? CFG : in_valid ? PT_WR : WAIT_IN;
            end
            PT_WR: begin
                m_valid = 1'b1;
                m_wen   = 1'b1;
                off     = 8'h14 + {4'h0, cnt[1:0], 2'b00};
                m_wdata = word(blk_r, cnt[1:0]);
                if (xfer && cnt == 4'd3) state_nx = GO;
            end
            GO: begin
                m_valid = 1'b1;
                m_wen   = 1'b1;
                m_wdata = {27'h0, mode_r, encdec_r, 2'b10};
                if (xfer) state_nx = GAP;
            end
            GAP: state_nx = POLL;
            POLL: begin
                m_valid = 1'b1;
                off     = 8'h44;
                if (xfer && m_rdata[0]) state_nx = CT_RD;
                else if (poll_tmo) state_nx = IDLE;
            end
            CT_RD: begin
                m_valid = 1'b1;
                off     = 8'h34 + {4'h0, cnt[1:0], 2'b00};
                if (xfer && cnt == 4'd3) state_nx = OUT;
            end
            OUT: state_nx = out_ready ? WAIT_IN : OUT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            poll_cnt  <= '0;
            key_r     <= '0;
            iv_r      <= '0;
            blk_r     <= '0;
            encdec_r  <= 1'b0;
            mode_r    <= '0;
            out_block <= '0;
            error     <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= state_nx != state ? '0 : xfer ? cnt + 4'd1 : cnt;
            poll_cnt <= state != POLL ? '0 : xfer ? poll_cnt + PW'(1) : poll_cnt;
            if (cfg_acc) begin
                key_r    <= cfg_key;
                iv_r     <= cfg_iv;
                encdec_r <= cfg_encdec;
                mode_r   <= cfg_mode;
            end
            error <= cfg_acc ? 1'b0 : poll_tmo ? 1'b1 : error;
            if (in_valid && in_ready) blk_r <= in_block;
            if (state == CT_RD && xfer)
                out_block <= {cnt[1:0] == 2'd0 ? m_rdata : out_block[127:96],
                              cnt[1:0] == 2'd1 ? m_rdata : out_block[95:64],
                              cnt[1:0] == 2'd2 ? m_rdata : out_block[63:32],
                              cnt[1:0] == 2'd3 ? m_rdata : out_block[31:0]};
        end
    end
endmodule

// File: tb/tb_aes_bus_sequencer.sv
// tb_aes_bus_sequencer: directed bench with a register-level AES slave model returning preset results.
module tb_aes_bus_sequencer;
    logic         clk = 0, resetn = 1, cfg_start = 0, cfg_encdec = 0;
    logic [127:0] cfg_key = '0, cfg_iv = '0, in_block = '0;
    logic [1:0]   cfg_mode = '0;
    logic         in_valid = 0, out_ready = 0;
    logic         in_ready, out_valid, m_valid, m_wen, m_ready, busy, error;
    logic [127:0] out_block;
    logic [23:0]  m_addr;
    logic [31:0]  m_wdata, m_rdata;
    int checks = 0, errors = 0;

    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] IV2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CP1 = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] CC1 = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] CP2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] CC2 = 128'h5086cb9b507219ee95db113a917678b2;

    always #5 clk = ~clk;

    aes_bus_sequencer #(.BASE_ADDR(24'h000000), .POLL_LIMIT(8)) dut (
        .clk(clk), .resetn(resetn), .cfg_start(cfg_start), .cfg_key(cfg_key), .cfg_iv(cfg_iv),
        .cfg_encdec(cfg_encdec), .cfg_mode(cfg_mode), .in_valid(in_valid), .in_ready(in_ready),
        .in_block(in_block), .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
        .m_valid(m_valid), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .m_ready(m_ready), .busy(busy), .error(error));

    // slave model: transfers are logged mid-cycle, result words come from ct_result
    logic         rdy_all = 1, stuck = 0, status = 0;
    logic [127:0] ct_result = '0;
    logic [31:0]  regs [0:17];
    int lat = 0, cyc = 0, log_n = 0, stall_viol = 0, ov_cnt = 0;
    logic [23:0]  log_addr [0:511];
    logic         log_wen  [0:511];
    logic [31:0]  log_data [0:511];
    int           log_cyc  [0:511];
    logic         pend = 0, p_wen = 0;
    logic [23:0]  p_addr = '0;
    logic [31:0]  p_data = '0;

    function automatic logic [31:0] wsel(input logic [127:0] v, input int i);
        return v[127 - 32 * i -: 32];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;
    assign m_ready = rdy_all || (cyc % 3 == 0);
    always_comb
        m_rdata = m_addr == 24'h44 ? {31'h0, status && !stuck}
                : (m_addr >= 24'h34 && m_addr <= 24'h40) ? wsel(ct_result, int'((m_addr - 24'h34) >> 2))
                : regs[m_addr[6:2]];

    always @(negedge clk) begin
        if (lat > 0) begin
            lat <= lat - 1;
            if (lat == 1) status <= 1;
        end
        if (m_valid && m_ready && resetn) begin
            log_addr[log_n] <= m_addr;
            log_wen[log_n]  <= m_wen;
            log_data[log_n] <= m_wdata;
            log_cyc[log_n]  <= cyc;
            log_n <= log_n + 1;
            if (m_wen) begin
                regs[m_addr[6:2]] <= m_wdata;
                if (m_addr == 24'h0 && (m_wdata[0] || m_wdata[1])) status <= 0;
                if (m_addr == 24'h0 && m_wdata[1]) lat <= 3;
            end
        end
        if (pend && (m_valid !== 1'b1 || m_addr !== p_addr || m_wdata !== p_data || m_wen !== p_wen))
            stall_viol <= stall_viol + 1;
        pend   <= m_valid && !m_ready && resetn;
        p_addr <= m_addr;
        p_data <= m_wdata;
        p_wen  <= m_wen;
        if (out_valid) ov_cnt <= ov_cnt + 1;
    end

    task automatic do_cfg(input logic [127:0] k, input logic [127:0] iv, input logic e, input logic [1:0] md);
        @(negedge clk);
        cfg_key = k; cfg_iv = iv; cfg_encdec = e; cfg_mode = md; cfg_start = 1;
        @(negedge clk);
        cfg_start = 0;
    endtask

    task automatic send_block(input logic [127:0] b);
        int n = 0;
        while (!in_ready && n < 2000) begin @(negedge clk); n++; end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL send_block: in_ready=%b after %0d cycles, want 1", in_ready, n);
        end else begin
            in_block = b; in_valid = 1;
            @(negedge clk);
            in_valid = 0;
        end
    endtask

    task automatic wait_out();
        int n = 0;
        while (!out_valid && n < 2000) begin @(negedge clk); n++; end
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL wait_out: out_valid=%b after %0d cycles, want 1", out_valid, n);
        end
    endtask

    task automatic take_out(output logic [127:0] got);
        wait_out();
        got = out_block;
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
    endtask

    task automatic test_reset();
        #2 resetn = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({m_valid, m_wen, m_addr, m_wdata, in_ready, out_valid, out_block, busy, error} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b addr=%h out_block=%h busy=%b error=%b, want all 0",
                     m_valid, m_addr, out_block, busy, error);
        end
        resetn = 1;
        repeat (4) @(negedge clk);
        checks++;
        if (in_ready !== 0 || busy !== 0) begin
            errors++;
            $display("FAIL reset_idle: in_ready=%b busy=%b, want 0 0", in_ready, busy);
        end
    endtask

    task automatic test_ecb_encrypt();
        int base, n;
        logic [127:0] got;
        logic [23:0] ea;
        logic ew;
        logic [31:0] ed;
        base = log_n;
        ct_result = C1;
        do_cfg(K1, '0, 1, 2'b00);
        send_block(P1);
        take_out(got);
        checks++;
        if (got !== C1) begin errors++; $display("FAIL ecb_enc_out: got %h want %h", got, C1); end
        checks++;
        if (out_valid !== 0) begin errors++; $display("FAIL ecb_out_drop: out_valid=%b want 0", out_valid); end
        repeat (2) @(negedge clk);
        n = log_n - base;
        checks++;
        if (n < 20 || n > 27) begin
            errors++;
            $display("FAIL ecb_trace_len: got %0d transfers, want 20..27", n);
        end else begin
            for (int j = 0; j < n; j++) begin
                if (j < 10) begin
                    ea = j < 2 ? 24'h0 : j < 6 ? 24'(4 * (j - 1)) : 24'(24'h24 + 4 * (j - 6));
                    ew = 1;
                    ed = j == 0 ? 32'h1 : j == 1 ? 32'h04 : j < 6 ? wsel(K1, j - 2) : 32'h0;
                end else if (j < 14) begin
                    ea = 24'(24'h14 + 4 * (j - 10)); ew = 1; ed = wsel(P1, j - 10);
                end else if (j == 14) begin
                    ea = 24'h0; ew = 1; ed = 32'h06;
                end else if (j < n - 4) begin
                    ea = 24'h44; ew = 0; ed = 32'h0;
                end else begin
                    ea = 24'(24'h34 + 4 * (j - (n - 4))); ew = 0; ed = 32'h0;
                end
                checks++;
                if (log_addr[base+j] !== ea || log_wen[base+j] !== ew || (ew && log_data[base+j] !== ed)) begin
                    errors++;
                    $display("FAIL ecb_trace[%0d]: got addr=%h wen=%b data=%h want addr=%h wen=%b data=%h",
                             j, log_addr[base+j], log_wen[base+j], log_data[base+j], ea, ew, ed);
                end
            end
            checks++;
            if (log_cyc[base+15] - log_cyc[base+14] !== 2) begin
                errors++;
                $display("FAIL ecb_gap: first poll %0d cycles after GO, want 2", log_cyc[base+15] - log_cyc[base+14]);
            end
        end
    endtask

    task automatic test_ecb_decrypt();
        int base;
        logic [127:0] got;
        base = log_n;
        ct_result = P1;
        do_cfg(K1, '0, 0, 2'b00);
        send_block(C1);
        take_out(got);
        checks++;
        if (got !== P1) begin errors++; $display("FAIL ecb_dec_out: got %h want %h", got, P1); end
        checks++;
        if (log_data[base+1] !== 32'h00) begin
            errors++; $display("FAIL dec_release: got %h want 00000000", log_data[base+1]);
        end
        checks++;
        if (log_addr[base+14] !== 24'h0 || log_wen[base+14] !== 1 || log_data[base+14] !== 32'h02) begin
            errors++;
            $display("FAIL dec_go: got addr=%h wen=%b data=%h want 000000 1 00000002",
                     log_addr[base+14], log_wen[base+14], log_data[base+14]);
        end
    endtask

    task automatic test_cbc();
        int base, gos, ivw;
        logic [127:0] got1, got2;
        base = log_n;
        ct_result = CC1;
        do_cfg(K2, IV2, 1, 2'b01);
        send_block(CP1);
        take_out(got1);
        ct_result = CC2;
        send_block(CP2);
        take_out(got2);
        repeat (2) @(negedge clk);
        checks++;
        if (got1 !== CC1) begin errors++; $display("FAIL cbc_out1: got %h want %h", got1, CC1); end
        checks++;
        if (got2 !== CC2) begin errors++; $display("FAIL cbc_out2: got %h want %h", got2, CC2); end
        gos = 0; ivw = 0;
        for (int j = base; j < log_n; j++) begin
            if (log_wen[j] && log_addr[j] == 24'h0 && log_data[j] == 32'h0E) gos++;
            if (log_wen[j] && log_addr[j] >= 24'h24 && log_addr[j] <= 24'h30) ivw++;
        end
        checks++;
        if (gos !== 2) begin errors++; $display("FAIL cbc_go: got %0d GO writes of 0E, want 2", gos); end
        checks++;
        if (ivw !== 4) begin errors++; $display("FAIL cbc_iv_writes: got %0d, want 4", ivw); end
        checks++;
        if (log_data[base+6] !== wsel(IV2, 0) || log_data[base+1] !== 32'h0C) begin
            errors++;
            $display("FAIL cbc_cfg: iv0=%h release=%h want %h 0000000c", log_data[base+6], log_data[base+1], wsel(IV2, 0));
        end
    endtask

    task automatic test_backpressure();
        int base, v0, pt, ct, cf, bad;
        logic [127:0] first;
        logic [127:0] got;
        rdy_all = 0;
        v0 = stall_viol;
        base = log_n;
        ct_result = 128'hdeadbeef_01234567_89abcdef_cafef00d;
        do_cfg(K1, IV2, 1, 2'b00);
        send_block(P1);
        wait_out();
        first = out_block;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_block !== first || out_valid !== 1) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL bp_out_stable: %0d unstable cycles, want 0", bad); end
        take_out(got);
        checks++;
        if (got !== ct_result) begin errors++; $display("FAIL bp_out: got %h want %h", got, ct_result); end
        rdy_all = 1;
        repeat (2) @(negedge clk);
        checks++;
        if (stall_viol - v0 !== 0) begin
            errors++; $display("FAIL bp_bus_stable: %0d stalled request changes, want 0", stall_viol - v0);
        end
        pt = 0; ct = 0; cf = 0;
        for (int j = base; j < log_n; j++) begin
            if (log_wen[j] && log_addr[j] >= 24'h14 && log_addr[j] <= 24'h20) begin
                if (log_addr[j] == 24'(24'h14 + 4 * pt) && log_data[j] == wsel(P1, pt)) pt++;
                else pt += 100;
            end
            if (!log_wen[j] && log_addr[j] >= 24'h34 && log_addr[j] <= 24'h40) ct++;
            if (log_wen[j] && log_addr[j] <= 24'h10 && log_data[j] != 32'h06) cf++;
        end
        checks++;
        if (pt !== 4 || ct !== 4) begin
            errors++; $display("FAIL bp_no_dup: pt score=%0d ct reads=%0d, want 4 4", pt, ct);
        end
        checks++;
        if (cf !== 6) begin errors++; $display("FAIL bp_cfg_count: got %0d CTRL/KEY writes, want 6", cf); end
    endtask

    task automatic test_timeout();
        int base, n, polls, ov0, base2, pts;
        stuck = 1;
        base = log_n;
        ov0 = ov_cnt;
        do_cfg(K1, '0, 1, 2'b00);
        send_block(P1);
        n = 0;
        while (!error && n < 300) begin @(negedge clk); n++; end
        checks++;
        if (error !== 1) begin errors++; $display("FAIL tmo_error: error=%b want 1", error); end
        polls = 0;
        for (int j = base; j < log_n; j++) if (!log_wen[j] && log_addr[j] == 24'h44) polls++;
        checks++;
        if (polls !== 8) begin errors++; $display("FAIL tmo_polls: got %0d status reads, want 8", polls); end
        checks++;
        if (busy !== 0 || in_ready !== 0 || ov_cnt !== ov0) begin
            errors++;
            $display("FAIL tmo_idle: busy=%b in_ready=%b out_valid cycles=%0d want 0 0 0", busy, in_ready, ov_cnt - ov0);
        end
        stuck = 0;
        do_cfg(K1, '0, 1, 2'b00);
        checks++;
        if (error !== 0 || busy !== 1) begin
            errors++; $display("FAIL tmo_clear: error=%b busy=%b want 0 1", error, busy);
        end
        n = 0;
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        base2 = log_n;
        cfg_start = 1; in_valid = 1; in_block = CP2;
        #1;
        checks++;
        if (in_ready !== 0) begin errors++; $display("FAIL collide_ready: in_ready=%b want 0", in_ready); end
        @(negedge clk);
        cfg_start = 0; in_valid = 0;
        n = 0;
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        pts = 0;
        for (int j = base2; j < log_n; j++) if (log_wen[j] && log_addr[j] >= 24'h14 && log_addr[j] <= 24'h20) pts++;
        checks++;
        if (log_n - base2 !== 10 || pts !== 0 || log_data[base2] !== 32'h1 || log_addr[base2] !== 24'h0) begin
            errors++;
            $display("FAIL collide_cfg: transfers=%0d pt_writes=%0d first=%h@%h want 10 0 00000001@000000",
                     log_n - base2, pts, log_data[base2], log_addr[base2]);
        end
    endtask

    task automatic test_reset_mid_ct();
        int n = 0;
        ct_result = C1;
        send_block(P1);
        while (!(m_valid && !m_wen && m_addr == 24'h3C) && n < 500) begin @(negedge clk); n++; end
        resetn = 0;
        #1;
        checks++;
        if ({m_valid, m_wen, m_addr, m_wdata, in_ready, out_valid, out_block, busy, error} !== '0) begin
            errors++;
            $display("FAIL reset_mid_ct: valid=%b addr=%h out_block=%h busy=%b, want all 0", m_valid, m_addr, out_block, busy);
        end
        @(negedge clk);
        resetn = 1;
        repeat (5) @(negedge clk);
        checks++;
        if (in_ready !== 0 || busy !== 0) begin
            errors++; $display("FAIL reset_mid_ct_idle: in_ready=%b busy=%b want 0 0", in_ready, busy);
        end
    endtask

    initial begin
        test_reset();
        test_ecb_encrypt();
        test_ecb_decrypt();
        test_cbc();
        test_backpressure();
        test_timeout();
        test_reset_mid_ct();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
